// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encoding and the bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width: enough bits to count 0..WIDTH-1, never less than one.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// 1-bit full subtractor built from two half subtractors: the first
// subtracts B from A, the second subtracts the incoming borrow from that
// partial difference; either stage borrowing produces a borrow out.
module full_sub_cell (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    logic d1;
    logic b1;
    logic b2;

    half_sub u_hs_ab (
        .a      (A),
        .b      (B),
        .diff   (d1),
        .borrow (b1)
    );

    half_sub u_hs_bin (
        .a      (d1),
        .b      (Bin),
        .diff   (Diff),
        .borrow (b2)
    );

    assign Bout = b1 | b2;

endmodule

// File: rtl/half_sub.sv
// 1-bit half subtractor: diff = a - b, borrow set when b exceeds a.
module half_sub (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b;
    assign borrow = ~a & b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller. One full-subtractor cell and a
// borrow flip-flop process the operands LSB first, one bit per clock.
// A Start in IDLE captures A/B; WIDTH RUN cycles later the DONE cycle
// presents Diff/Borrow with a one-cycle Done pulse. Diff/Borrow hold until
// the next completion or reset.
// Optional build macro SERIAL_SUB_OVF_EN adds the Ovf output (signed
// two's-complement overflow of A - B), registered and held like Diff.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    // Holds the first WIDTH-1 result bits; the last bit comes straight
    // from the cell when the result is committed.
    logic [WIDTH-2:0] sd;
    logic             bq;
    logic [CNT_W-1:0] cnt;
    logic             d;
    logic             bn;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept aside because SA/SB shift them away.
    logic             a_msb;
    logic             b_msb;
`endif

    full_sub_cell u_cell (
        .A    (sa[0]),
        .B    (sb[0]),
        .Bin  (bq),
        .Diff (d),
        .Bout (bn)
    );

    // Sequencer FSM: capture, shift one bit per cycle, commit result, pulse Done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            bq     <= 1'b0;
            cnt    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Diff   <= '0;
            Borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            Ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        sa    <= A;
                        sb    <= B;
                        bq    <= 1'b0;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= ST_RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= (WIDTH-1)'({d, sd} >> 1);
                    bq  <= bn;
                    cnt <= cnt + CNT_ONE;
                    if (cnt == LAST_BIT) begin
                        // Commit on the way into DONE so the result is
                        // already valid in the Done cycle.
                        Diff   <= {d, sd};
                        Borrow <= bn;
                        Done   <= 1'b1;
                        state  <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        Ovf    <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
                    end
                end
                ST_DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8). A transaction-level model
// (remaining-busy-cycles counter plus the arithmetic result) is compared
// against the DUT outputs on every falling edge; directed operations also
// check hand-computed results and the Done latency.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Diff;
    logic         Borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .Diff   (Diff),
        .Borrow (Borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf    (Ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Model: an accepted request keeps the unit busy for W+1 cycles, the
    // last of which is the Done cycle where the arithmetic result appears.
    int           m_left   = 0;
    logic [W-1:0] m_diff   = '0;
    logic         m_borrow = 1'b0;
    logic         m_ovf    = 1'b0;
    logic [W-1:0] p_diff   = '0;
    logic         p_borrow = 1'b0;
    logic         p_ovf    = 1'b0;
    bit           armed    = 1'b0;

    always @(posedge clk) begin
        armed = 1'b1;
        if (rst) begin
            m_left   = 0;
            m_diff   = '0;
            m_borrow = 1'b0;
            m_ovf    = 1'b0;
        end else if (m_left == 0) begin
            if (Start) begin
                m_left   = W + 1;
                p_diff   = A - B;
                p_borrow = (A < B);
                p_ovf    = (A[W-1] ^ B[W-1]) & (A[W-1] ^ p_diff[W-1]);
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) begin
                m_diff   = p_diff;
                m_borrow = p_borrow;
                m_ovf    = p_ovf;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cyc_busy",   Busy,   m_left > 0);
            check("cyc_done",   Done,   m_left == 1);
            check("cyc_diff",   Diff,   m_diff);
            check("cyc_borrow", Borrow, m_borrow);
`ifdef SERIAL_SUB_OVF_EN
            check("cyc_ovf",    Ovf,    m_ovf);
`endif
        end
    end

    // One operation from IDLE; optionally pokes Start during RUN and DONE.
    // Returns in the Done cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_d, input logic exp_b,
                         input bit poke, input string name);
        int got;
        got = 0;
        @(posedge clk); #1;
        A = a; B = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        A = ~a;
        B = a;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (poke && i == 3) begin
                Start = 1'b1;
                A = 8'h11;
                B = 8'h22;
            end
            if (poke && i == 4) Start = 1'b0;
            if (Done) begin
                got = i;
                break;
            end
        end
        check({name, "_latency"}, got, W + 1);
        check({name, "_diff"},    Diff, exp_d);
        check({name, "_borrow"},  Borrow, exp_b);
        check({name, "_model"},   m_diff, exp_d);
        if (poke) begin
            Start = 1'b1;
            @(posedge clk); #1;
            Start = 1'b0;
        end
    endtask

    initial begin
        int prev;
        int ndone;
        int cnt;

        // Reset held with Start asserted: nothing may start.
        rst = 1'b1; Start = 1'b1; A = 8'd5; B = 8'd1;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy",   Busy, 1'b0);
            check("rst_done",   Done, 1'b0);
            check("rst_diff",   Diff, 8'd0);
            check("rst_borrow", Borrow, 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0; Start = 1'b0;

        do_op(8'd100, 8'd37, 8'd63,  1'b0, 1'b0, "op_100_37");
        do_op(8'd5,   8'd9,  8'hFC,  1'b1, 1'b1, "op_5_9");
        do_op(8'hAA,  8'hAA, 8'h00,  1'b0, 1'b0, "op_aa_aa");
        do_op(8'd0,   8'd1,  8'hFF,  1'b1, 1'b0, "op_0_1");

        // Start held high: one result every W+2 cycles.
        @(posedge clk); #1;
        A = 8'd20; B = 8'd3; Start = 1'b1;
        prev = -1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) begin
                check("cont_diff", Diff, 8'd17);
                if (prev >= 0) check("cont_gap", i - prev, 10);
                prev = i;
                ndone++;
            end
        end
        Start = 1'b0;
        check("cont_count", ndone, 4);

        // Reset in the fourth RUN cycle discards the operation.
        @(posedge clk); #1;
        A = 8'd100; B = 8'd1; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy",   Busy, 1'b0);
        check("midrst_done",   Done, 1'b0);
        check("midrst_diff",   Diff, 8'd0);
        check("midrst_borrow", Borrow, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (Done) cnt++;
        end
        check("midrst_nodone", cnt, 0);
        do_op(8'd7, 8'd2, 8'd5, 1'b0, 1'b0, "op_7_2");

`ifdef SERIAL_SUB_OVF_EN
        do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, "ovf_80_01");
        check("ovf_80_01_ovf", Ovf, 1'b1);
        do_op(8'h10, 8'h05, 8'h0B, 1'b0, 1'b0, "ovf_10_05");
        check("ovf_10_05_ovf", Ovf, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
